// File: rtl/c_pseq.sv
// Power sequencer: enables rails in ascending order and waits for each power-good.
// It then holds system reset, runs, and powers down in reverse order. Any rail loss or timeout latches a fault.
module c_pseq #(
   parameter int N     = 3,
   parameter int T_PG  = 200,
   parameter int T_GAP = 10,
   parameter int T_RST = 50,
   parameter int T_OFF = 10,
   parameter int CW    = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwr_req,
   input  logic [N-1:0] pg,
   output logic [N-1:0] en,
   output logic         rst_out_n,
   output logic         fault,
   output logic [2:0]   state
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_ON_WAIT  = 3'd1,
      S_ON_GAP   = 3'd2,
      S_RST_HOLD = 3'd3,
      S_RUN      = 3'd4,
      S_OFF_SEQ  = 3'd5,
      S_FAULT    = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N-1:0]    en_q, en_d;
   logic            rst_out_n_q, rst_out_n_d;
   logic            fault_q, fault_d;

   logic            req_meta_q, req_s_q;
   logic [N-1:0]    pg_meta_q, pg_s_q;
   logic [N-1:0]    pg_good_raw;

   logic [N-1:0]    below_idx, upto_idx, onehot_cur, onehot_inc;
   logic [IW-1:0]   idx_inc;
   logic [CW-1:0]   timer_inc;
   logic            loss_lt, loss_le, cur_good, last_rail;

   // Open-drain pg: anything but a hard 0 (including a floating z) counts as good.
   for (genvar gi = 0; gi < N; gi++) begin : g_rail
      assign pg_good_raw[gi] = (pg[gi] !== 1'b0);
      assign below_idx[gi]   = (idx_q > IW'(gi));
      assign upto_idx[gi]    = (idx_q >= IW'(gi));
      assign onehot_cur[gi]  = (idx_q == IW'(gi));
      assign onehot_inc[gi]  = (idx_inc == IW'(gi));
   end

   assign idx_inc   = idx_q + 1'b1;
   assign timer_inc = (timer_q == {CW{1'b1}}) ? timer_q : timer_q + 1'b1;
   assign loss_lt   = |(below_idx & ~pg_s_q);
   assign loss_le   = |(upto_idx & ~pg_s_q);
   assign cur_good  = pg_s_q[idx_q];
   assign last_rail = (idx_q == IW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_meta_q <= 1'b0;
         req_s_q    <= 1'b0;
         pg_meta_q  <= '0;
         pg_s_q     <= '0;
      end else begin
         req_meta_q <= pwr_req;
         req_s_q    <= req_meta_q;
         pg_meta_q  <= pg_good_raw;
         pg_s_q     <= pg_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OFF;
         timer_q     <= '0;
         idx_q       <= '0;
         en_q        <= '0;
         rst_out_n_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         en_q        <= en_d;
         rst_out_n_q <= rst_out_n_d;
         fault_q     <= fault_d;
      end
   end

   // Priority in every active state: rail fault, then power-request drop, then progress.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_inc;
      idx_d       = idx_q;
      en_d        = en_q;
      rst_out_n_d = rst_out_n_q;
      fault_d     = fault_q;
      case (state_q)
         S_OFF: begin
            if (req_s_q) begin
               state_d = S_ON_WAIT;
               idx_d   = '0;
               en_d    = N'(1);
               timer_d = '0;
            end
         end
         S_ON_WAIT: begin
            if (loss_lt || (!cur_good && timer_q == CW'(T_PG - 1))) begin
               state_d = S_FAULT;
            end else if (!req_s_q) begin
               state_d = S_OFF_SEQ;
            end else if (cur_good) begin
               state_d = last_rail ? S_RST_HOLD : S_ON_GAP;
               timer_d = '0;
            end
         end
         S_ON_GAP: begin
            if (loss_le) begin
               state_d = S_FAULT;
            end else if (!req_s_q) begin
               state_d = S_OFF_SEQ;
            end else if (timer_q == CW'(T_GAP - 1)) begin
               state_d = S_ON_WAIT;
               idx_d   = idx_inc;
               en_d    = en_q | onehot_inc;
               timer_d = '0;
            end
         end
         S_RST_HOLD: begin
            if (loss_le) begin
               state_d = S_FAULT;
            end else if (!req_s_q) begin
               state_d = S_OFF_SEQ;
            end else if (timer_q == CW'(T_RST - 1)) begin
               state_d     = S_RUN;
               rst_out_n_d = 1'b1;
               timer_d     = '0;
            end
         end
         S_RUN: begin
            if (loss_le) begin
               state_d = S_FAULT;
            end else if (!req_s_q) begin
               state_d = S_OFF_SEQ;
            end
         end
         S_OFF_SEQ: begin
            if (timer_q == CW'(T_OFF - 1)) begin
               en_d    = en_q & ~onehot_cur;
               timer_d = '0;
               if (idx_q == '0) begin
                  state_d = S_OFF;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         S_FAULT: begin
            if (!req_s_q) begin
               state_d = S_OFF;
               fault_d = 1'b0;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_OFF;
            timer_d = '0;
         end
      endcase
      // Entry actions shared by every path into FAULT / OFF_SEQ.
      if (state_d == S_FAULT && state_q != S_FAULT) begin
         en_d        = '0;
         rst_out_n_d = 1'b0;
         fault_d     = 1'b1;
         timer_d     = '0;
      end else if (state_d == S_OFF_SEQ && state_q != S_OFF_SEQ) begin
         rst_out_n_d = 1'b0;
         timer_d     = '0;
      end
   end

   assign en        = en_q;
   assign rst_out_n = rst_out_n_q;
   assign fault     = fault_q;
   assign state     = state_q;

endmodule

// File: tb/tb_c_pseq.sv
// Directed bench for c_pseq (N=3, T_PG=20, T_GAP=5, T_RST=10, T_OFF=5) with simple rail models on pg.
// Latencies are counted in clk edges from the stimulus edge: 2 sync flops plus 1 registered FSM step.
module tb_c_pseq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pwr_req = 1'b0;
   logic [2:0] pg;
   logic [2:0] en;
   logic       rst_out_n;
   logic       fault;
   logic [2:0] state;

   logic [2:0] pg_m = '0;
   logic [2:0] kill = '0;
   logic [1:0] cnt [3];

   int n_cmp = 0;
   int n_err = 0;
   int n;
   logic en2_seen;

   always #5 clk = ~clk;

   c_pseq #(.N(3), .T_PG(20), .T_GAP(5), .T_RST(10), .T_OFF(5), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .pg(pg),
      .en(en), .rst_out_n(rst_out_n), .fault(fault), .state(state)
   );

   // Each rail reports good on the 3rd clk after its enable rises; kill forces it low.
   for (genvar gi = 0; gi < 3; gi++) begin : g_rail
      always @(posedge clk) begin
         if (!en[gi]) begin
            cnt[gi]  <= 2'd0;
            pg_m[gi] <= 1'b0;
         end else if (cnt[gi] < 2'd2) begin
            cnt[gi] <= cnt[gi] + 2'd1;
         end else begin
            pg_m[gi] <= 1'b1;
         end
      end
   end
   assign pg = pg_m & ~kill;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      en2_seen = en2_seen | en[2];
   endtask

   function automatic int probe(input int sel);
      case (sel)
         0, 1, 2: probe = int'(en[sel]);
         3:       probe = int'(rst_out_n);
         4:       probe = int'(fault);
         default: probe = int'(state);
      endcase
   endfunction

   // Returns the number of edges until probe(sel)==val, or -1 when the budget runs out.
   task automatic wait_sig(input int sel, input int val, input int max, output int cycles);
      cycles = -1;
      for (int k = 1; k <= max; k++) begin
         step();
         if (probe(sel) == val) begin
            cycles = k;
            break;
         end
      end
   endtask

   localparam int EN0 = 0, EN1 = 1, EN2 = 2, RSTO = 3, FLT = 4, ST = 5;

   initial begin
      en2_seen = 1'b0;
      #12;
      chk("reset_en", int'(en), 0);
      chk("reset_rst_out_n", int'(rst_out_n), 0);
      chk("reset_fault", int'(fault), 0);
      chk("reset_state", int'(state), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: full power-up
      @(negedge clk);
      pwr_req = 1'b1;
      wait_sig(EN0, 1, 50, n);  chk("t1_en0_latency", n, 3);
      wait_sig(ST, 2, 50, n);   chk("t1_gap0_entry", n, 6);
      wait_sig(EN1, 1, 50, n);  chk("t1_en1_after_gap", n, 5);
      wait_sig(ST, 2, 50, n);   chk("t1_gap1_entry", n, 6);
      wait_sig(EN2, 1, 50, n);  chk("t1_en2_after_gap", n, 5);
      wait_sig(ST, 3, 50, n);   chk("t1_rst_hold_entry", n, 6);
      wait_sig(RSTO, 1, 50, n); chk("t1_rst_release", n, 10);
      chk("t1_state_run", int'(state), 4);
      chk("t1_en_all", int'(en), 7);

      // 2: orderly power-down
      @(negedge clk);
      pwr_req = 1'b0;
      wait_sig(RSTO, 0, 50, n); chk("t2_rst_assert", n, 3);
      chk("t2_state_off_seq", int'(state), 5);
      wait_sig(EN2, 0, 50, n);  chk("t2_en2_fall", n, 5);
      wait_sig(EN1, 0, 50, n);  chk("t2_en1_fall", n, 5);
      wait_sig(EN0, 0, 50, n);  chk("t2_en0_fall", n, 5);
      chk("t2_state_off", int'(state), 0);
      chk("t2_fault", int'(fault), 0);

      // 3: rail 1 never good -> timeout
      @(negedge clk);
      kill = 3'b010;
      pwr_req = 1'b1;
      wait_sig(EN0, 1, 50, n);  chk("t3_en0_latency", n, 3);
      wait_sig(EN1, 1, 50, n);  chk("t3_en1_latency", n, 11);
      wait_sig(FLT, 1, 50, n);  chk("t3_timeout", n, 20);
      chk("t3_en_cleared", int'(en), 0);
      chk("t3_state_fault", int'(state), 6);
      repeat (8) step();
      chk("t3_fault_persist", int'(fault), 1);
      @(negedge clk);
      pwr_req = 1'b0;
      wait_sig(ST, 0, 20, n);   chk("t3_exit_fault", n, 3);
      chk("t3_fault_cleared", int'(fault), 0);

      // 4: rail 0 drops while running
      @(negedge clk);
      kill = 3'b000;
      pwr_req = 1'b1;
      wait_sig(ST, 4, 100, n);  chk("t4_reach_run", n, 41);
      @(negedge clk);
      kill = 3'b001;
      wait_sig(ST, 6, 20, n);   chk("t4_fault_latency", n, 3);
      chk("t4_en_cleared", int'(en), 0);
      chk("t4_rst_out_n", int'(rst_out_n), 0);
      chk("t4_fault_flag", int'(fault), 1);
      @(negedge clk);
      kill = 3'b000;
      repeat (10) step();
      chk("t4_fault_persist_state", int'(state), 6);
      chk("t4_fault_persist_flag", int'(fault), 1);
      @(negedge clk);
      pwr_req = 1'b0;
      wait_sig(ST, 0, 20, n);   chk("t4_exit_fault", n, 3);

      // 5: request dropped during the gap after rail 1
      @(negedge clk);
      pwr_req = 1'b1;
      wait_sig(EN1, 1, 50, n);  chk("t5_en1_latency", n, 14);
      wait_sig(ST, 2, 50, n);   chk("t5_gap1_entry", n, 6);
      chk("t5_en_before_drop", int'(en), 3);
      en2_seen = 1'b0;
      pwr_req = 1'b0;
      wait_sig(ST, 5, 20, n);   chk("t5_off_seq_entry", n, 3);
      wait_sig(EN1, 0, 50, n);  chk("t5_en1_fall", n, 5);
      wait_sig(EN0, 0, 50, n);  chk("t5_en0_fall", n, 5);
      chk("t5_state_off", int'(state), 0);
      chk("t5_en2_never", int'(en2_seen), 0);

      // 6: asynchronous reset in RST_HOLD, then restart
      @(negedge clk);
      pwr_req = 1'b1;
      wait_sig(ST, 3, 100, n);  chk("t6_reach_rst_hold", n, 31);
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_en", int'(en), 0);
      chk("t6_rst_rst_out_n", int'(rst_out_n), 0);
      chk("t6_rst_state", int'(state), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_sig(EN0, 1, 50, n);  chk("t6_restart_en0", n, 3);
      wait_sig(ST, 4, 100, n);  chk("t6_restart_run", n, 38);
      chk("t6_rst_out_n_run", int'(rst_out_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
